// File: rtl/top_level.sv
// Stream-cipher engine: alternately encrypts a 41-byte message with an 8-bit LFSR
// keystream and decrypts it again, recovering the seed and tap from the known preamble.
module top_level (
    input  logic CLK,
    input  logic RESET,
    output logic done
);
    localparam int unsigned MSG_LEN   = 41;
    localparam int unsigned SCAN_LEN  = 9;
    localparam logic [7:0]  SPACE     = 8'h20;
    localparam logic [7:0]  PARM_BASE = 8'd41;
    localparam logic [7:0]  CT_BASE   = 8'd64;
    localparam logic        MODE_ENC  = 1'b0;
    localparam logic [7:0][7:0] TAPS  = {8'hF3, 8'hFA, 8'hB2, 8'hB4,
                                         8'hB8, 8'hC6, 8'hD4, 8'hE1};

    typedef enum logic [2:0] {
        S_LOAD, S_ENC_LOOP, S_DEC_SCAN, S_DEC_TAP, S_DEC_LOOP, S_DONE
    } state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] t);
        return {s[6:0], ^(s & t)};
    endfunction

    // True when tap t reproduces every observed transition s_{k-1} -> s_k.
    function automatic logic tap_fits(input logic [SCAN_LEN-1:0][7:0] obs, input logic [7:0] t);
        logic ok;
        ok = 1'b1;
        for (int k = 1; k < int'(SCAN_LEN); k++) begin
            if (lfsr_next(obs[4'(k - 1)], t) != obs[4'(k)]) ok = 1'b0;
        end
        return ok;
    endfunction

    state_t                     state_q, state_d;
    logic [5:0]                 cnt_q, cnt_d;
    logic [7:0]                 pre_q, pre_d;
    logic [7:0]                 tap_q, tap_d;
    logic [7:0]                 lfsr_q, lfsr_d;
    logic [SCAN_LEN-1:0][7:0]   obs_q, obs_d;
    logic                       started_q, started_d;
    logic [5:0]                 wr_ptr_q, wr_ptr_d;
    logic                       done_q, done_d;
    logic                       mode_q = MODE_ENC;
    logic                       mode_d;

    logic [7:0] rd_addr_c, rd_data_c, wr_addr_c, wr_data_c, byte_c;
    logic       we_c, mem_we_c, wr_go_c, in_msg_c;
    logic [8:0] cnt9_c, pre9_c;

    dm_ram data_mem (
        .clk     (CLK),
        .we      (mem_we_c),
        .wr_addr (wr_addr_c),
        .wr_data (wr_data_c),
        .rd_addr (rd_addr_c),
        .rd_data (rd_data_c)
    );

    assign mem_we_c = we_c & ~RESET;
    assign done     = done_q;

    // Next-state, datapath and memory-port control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pre_d     = pre_q;
        tap_d     = tap_q;
        lfsr_d    = lfsr_q;
        obs_d     = obs_q;
        started_d = started_q;
        wr_ptr_d  = wr_ptr_q;
        rd_addr_c = 8'd0;
        we_c      = 1'b0;
        wr_addr_c = 8'd0;
        wr_data_c = 8'd0;
        byte_c    = 8'd0;
        wr_go_c   = 1'b0;
        cnt9_c    = 9'(cnt_q);
        pre9_c    = 9'(pre_q);
        in_msg_c  = (cnt9_c >= pre9_c) && (cnt9_c < pre9_c + 9'(MSG_LEN));

        case (state_q)
            S_LOAD: begin
                if (mode_q == MODE_ENC) begin
                    rd_addr_c = PARM_BASE + 8'(cnt_q);
                    if (cnt_q == 6'd2) begin
                        lfsr_d  = rd_data_c;
                        cnt_d   = 6'd0;
                        state_d = S_ENC_LOOP;
                    end else begin
                        if (cnt_q == 6'd0) pre_d = rd_data_c;
                        else               tap_d = rd_data_c;
                        cnt_d = cnt_q + 6'd1;
                    end
                end else begin
                    cnt_d     = 6'd0;
                    started_d = 1'b0;
                    wr_ptr_d  = 6'd0;
                    state_d   = S_DEC_SCAN;
                end
            end
            S_ENC_LOOP: begin
                rd_addr_c = 8'(cnt9_c - pre9_c);
                byte_c    = in_msg_c ? rd_data_c : SPACE;
                we_c      = 1'b1;
                wr_addr_c = CT_BASE + 8'(cnt_q);
                wr_data_c = byte_c ^ lfsr_q;
                lfsr_d    = lfsr_next(lfsr_q, tap_q);
                cnt_d     = cnt_q + 6'd1;
                if (cnt_q == 6'd63) state_d = S_DONE;
            end
            S_DEC_SCAN: begin
                rd_addr_c             = CT_BASE + 8'(cnt_q);
                obs_d[cnt_q[3:0]]     = rd_data_c ^ SPACE;
                if (cnt_q == 6'(SCAN_LEN - 1)) begin
                    cnt_d   = 6'd0;
                    state_d = S_DEC_TAP;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DEC_TAP: begin
                // Descending scan so the lowest matching table index wins.
                tap_d = TAPS[0];
                for (int t = 7; t >= 0; t--) begin
                    if (tap_fits(obs_q, TAPS[3'(t)])) tap_d = TAPS[3'(t)];
                end
                lfsr_d  = obs_q[0];
                cnt_d   = 6'd0;
                state_d = S_DEC_LOOP;
            end
            S_DEC_LOOP: begin
                rd_addr_c = CT_BASE + 8'(cnt_q);
                byte_c    = rd_data_c ^ lfsr_q;
                wr_go_c   = started_q || (byte_c != SPACE);
                lfsr_d    = lfsr_next(lfsr_q, tap_q);
                cnt_d     = cnt_q + 6'd1;
                if (wr_go_c) begin
                    we_c      = 1'b1;
                    wr_addr_c = 8'(wr_ptr_q);
                    wr_data_c = byte_c;
                    wr_ptr_d  = wr_ptr_q + 6'd1;
                    started_d = 1'b1;
                end
                if (cnt_q == 6'd63 || (wr_go_c && wr_ptr_q == 6'(MSG_LEN - 1)))
                    state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        done_d = (state_d == S_DONE);
        mode_d = mode_q;
        if (!RESET && state_q != S_DONE && state_d == S_DONE) mode_d = ~mode_q;
    end

    // Mode survives reset so an aborted run repeats in the same direction.
    always_ff @(posedge CLK) begin
        mode_q <= mode_d;
        if (RESET) begin
            state_q   <= S_LOAD;
            cnt_q     <= '0;
            pre_q     <= '0;
            tap_q     <= '0;
            lfsr_q    <= '0;
            obs_q     <= '0;
            started_q <= 1'b0;
            wr_ptr_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            tap_q     <= tap_d;
            lfsr_q    <= lfsr_d;
            obs_q     <= obs_d;
            started_q <= started_d;
            wr_ptr_q  <= wr_ptr_d;
            done_q    <= done_d;
        end
    end
endmodule

// 256 x 8 data memory: combinational read, single synchronous write port.
module dm_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data
);
    logic [7:0] DM [0:255];

    always_ff @(posedge clk) begin
        if (we) DM[wr_addr] <= wr_data;
    end

    assign rd_data = DM[rd_addr];
endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: scripted and random encrypt/decrypt runs against a byte-level model.
module tb_top_level;
    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    logic done;

    top_level dut (.CLK(CLK), .RESET(RESET), .done(done));

    always #5 CLK = ~CLK;

    localparam logic [7:0] TAP_TBL [8] = '{8'hE1, 8'hD4, 8'hC6, 8'hB8, 8'hB4, 8'hB2, 8'hFA, 8'hF3};

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] mdl [256];
    int         pl_idx;
    bit         exp_enc = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shift left, feed back the parity of the tapped bits.
    function automatic logic [7:0] step(input logic [7:0] s, input logic [7:0] t);
        return 8'((int'(s) * 2) % 256 + ($countones(s & t) % 2));
    endfunction

    task automatic model_encrypt();
        int         pre = int'(mdl[41]);
        logic [7:0] tap = mdl[42];
        logic [7:0] s   = mdl[43];
        logic [7:0] plain;
        for (int i = 0; i < 64; i++) begin
            plain = (i >= pre && i < pre + 41) ? mdl[i - pre] : 8'h20;
            mdl[64 + i] = plain ^ s;
            s = step(s, tap);
        end
    endtask

    task automatic model_decrypt();
        logic [7:0] obs [9];
        logic [7:0] tap = 8'hE1;
        logic [7:0] s, p;
        bit found = 0, ok, started = 0;
        int w = 0;
        for (int k = 0; k < 9; k++) obs[k] = mdl[64 + k] ^ 8'h20;
        for (int t = 0; t < 8; t++) begin
            ok = 1;
            for (int k = 1; k < 9; k++)
                if (step(obs[k - 1], TAP_TBL[t]) != obs[k]) ok = 0;
            if (ok && !found) begin
                tap = TAP_TBL[t];
                found = 1;
            end
        end
        s = obs[0];
        for (int j = 0; j < 64; j++) begin
            p = mdl[64 + j] ^ s;
            s = step(s, tap);
            if (p != 8'h20) started = 1;
            if (started && w < 41) begin
                mdl[w] = p;
                w++;
            end
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 128; a++) mdl[a] = 8'($urandom);
    endtask

    task automatic set_msg(input string m);
        for (int i = 0; i < 41; i++) mdl[i] = (i < m.len()) ? 8'(m[i]) : 8'h20;
    endtask

    task automatic setup_encrypt(input string m, input int pre, input logic [7:0] tap, input logic [7:0] s0);
        fill_random();
        set_msg(m);
        mdl[41] = 8'(pre);
        mdl[42] = tap;
        mdl[43] = s0;
    endtask

    // Ciphertext comes from the model's own encryption; DM[0:63] is then scrambled.
    task automatic setup_decrypt(input string m, input int pre, input logic [7:0] tap, input logic [7:0] s0);
        setup_encrypt(m, pre, tap, s0);
        model_encrypt();
        for (int a = 0; a < 64; a++) mdl[a] = 8'($urandom);
    endtask

    function automatic string rand_msg();
        string m = "";
        for (int i = 0; i < 41; i++)
            m = {m, string'(($urandom_range(0, 4) == 0) ? 8'h20 : 8'($urandom_range(33, 126)))};
        return m;
    endfunction

    task preload();
        pl_idx = 0;
        while (pl_idx < 128) begin
            dut.data_mem.DM[pl_idx] <= mdl[pl_idx];
            pl_idx++;
        end
    endtask

    task automatic run_check(input string name);
        int cyc  = 0;
        int drop = 0;
        preload();
        @(negedge CLK);
        RESET = 1'b0;
        while (cyc < 300) begin
            @(negedge CLK);
            cyc++;
            if (done === 1'b1) break;
        end
        check({name, "_done_rise"}, 32'(done), 1);
        check({name, "_lat_ge8"}, 32'(cyc >= 8), 1);
        check({name, "_lat_le160"}, 32'(cyc <= 160), 1);
        if (exp_enc) model_encrypt();
        else         model_decrypt();
        exp_enc = !exp_enc;
        repeat (6) begin
            @(negedge CLK);
            if (done !== 1'b1) drop++;
        end
        check({name, "_done_hold"}, 32'(drop), 0);
        for (int a = 0; a < 128; a++)
            check($sformatf("%s_dm%0d", name, a), 32'(dut.data_mem.DM[a]), 32'(mdl[a]));
        RESET = 1'b1;
        @(negedge CLK);
        check({name, "_rst_done"}, 32'(done), 0);
    endtask

    initial begin
        @(negedge CLK);
        check("reset_done", 32'(done), 0);

        // Encrypt aborted after 20 cycles, then rerun in the same mode.
        setup_encrypt("Mr. Watson, come here. I want to see you.", 9, 8'hD4, 8'($urandom) | 8'h40);
        preload();
        @(negedge CLK);
        RESET = 1'b0;
        repeat (20) @(negedge CLK);
        check("abort_done_low", 32'(done), 0);
        RESET = 1'b1;
        @(negedge CLK);
        check("abort_rst_done", 32'(done), 0);
        check("abort_keep_pre", 32'(dut.data_mem.DM[41]), 32'(mdl[41]));
        run_check("watson_enc");

        setup_decrypt("Knowledge comes, but wisdom lingers.     ", 9, 8'hB4, 8'($urandom_range(1, 255)));
        run_check("wisdom_dec");

        setup_encrypt("  01234546789abcdefghijklmnopqrstuvwxyz. ", 11, 8'hB2, 8'($urandom_range(1, 255)));
        run_check("alnum_enc");

        setup_decrypt("  f       A joke is a very serious thing.", 10, 8'hFA, 8'($urandom_range(1, 255)));
        run_check("joke_dec");

        for (int r = 0; r < 2; r++) begin
            setup_encrypt(rand_msg(), $urandom_range(9, 23), TAP_TBL[$urandom_range(0, 7)],
                          8'($urandom_range(1, 255)));
            run_check($sformatf("rand_enc%0d", r));
            setup_decrypt(rand_msg(), $urandom_range(9, 23), TAP_TBL[$urandom_range(0, 7)],
                          8'($urandom_range(1, 255)));
            run_check($sformatf("rand_dec%0d", r));
        end

        setup_encrypt(rand_msg(), 23, TAP_TBL[$urandom_range(0, 7)], 8'($urandom_range(1, 255)));
        run_check("edge_pre23_enc");
        setup_decrypt("", 9, TAP_TBL[$urandom_range(0, 7)], 8'($urandom_range(1, 255)));
        run_check("blank_dec");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
